// File: rtl/ctrl_mc_if.sv
// ctrl_mc_if: control/handshake bundle between the SISC multi-cycle
// controller and its datapath (register file, ALU, PC/IR, data memory).
// The master side is the controller; the slave side is the datapath.
interface ctrl_mc_if #(
    parameter int OP_W  = 4,
    parameter int CC_W  = 4,
    parameter int ALU_W = 4
);
    logic [OP_W-1:0]  opcode;
    logic [CC_W-1:0]  mm;
    logic [CC_W-1:0]  stat;
    logic             mem_ack;
    logic             rf_we;
    logic             wb_sel;
    logic [ALU_W-1:0] alu_op;
    logic             br_sel;
    logic             pc_sel;
    logic             pc_write;
    logic             pc_rst;
    logic             ir_load;
    logic             mem_req;
    logic             mem_we;
    logic             halted;
    logic             mem_err;

    modport master (
        input  opcode, mm, stat, mem_ack,
        output rf_we, wb_sel, alu_op, br_sel, pc_sel, pc_write, pc_rst,
               ir_load, mem_req, mem_we, halted, mem_err
    );

    modport slave (
        output opcode, mm, stat, mem_ack,
        input  rf_we, wb_sel, alu_op, br_sel, pc_sel, pc_write, pc_rst,
               ir_load, mem_req, mem_we, halted, mem_err
    );
endinterface

// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle control FSM for the SISC datapath.
// FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK, with early retire of
// branches/NOOP from DECODE, a req/ack data-memory handshake with timeout,
// and a sticky HALT state left only through rst_f.
// Optional build macro CTRL_MC_PERF_CNT_EN adds retired/stall counters.
module ctrl_mc #(
    parameter int OP_W     = 4,
    parameter int CC_W     = 4,
    parameter int ALU_W    = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_f,
    ctrl_mc_if.master   bus
`ifdef CTRL_MC_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);
    localparam logic [2:0] ST_START   = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_MEM     = 3'd4;
    localparam logic [2:0] ST_WB      = 3'd5;
    localparam logic [2:0] ST_HALT    = 3'd6;

    localparam logic [3:0] OP_NOOP   = 4'd0;
    localparam logic [3:0] OP_REG_OP = 4'd1;
    localparam logic [3:0] OP_REG_IM = 4'd2;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_BNE    = 4'd6;
    localparam logic [3:0] OP_BNR    = 4'd7;
    localparam logic [3:0] OP_LOD    = 4'd10;
    localparam logic [3:0] OP_STR    = 4'd11;
    localparam logic [3:0] OP_HLT    = 4'd15;

    // The wait counter only needs to reach WAIT_MAX-1: the timeout fires in
    // the WAIT_MAX-th MEM cycle, where a coincident ack still wins.
    localparam int              CNT_W      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic            TIMEOUT_EN = (WAIT_MAX != 0);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             halted_r;
    logic             mem_err_r;
    logic [3:0]       op_s;
    logic [CC_W-1:0]  cc_hit_s;
    logic             cond_s;
    logic             is_branch_s;
    logic             br_taken_s;
    logic             br_abs_s;
    logic             is_mem_op_s;
    logic             timeout_s;

    // Unknown encodings, or any set bit above the low nibble, act as NOOP.
    function automatic logic [3:0] decode_op(input logic [OP_W-1:0] raw);
        logic [3:0] low;
        low = raw[3:0];
        if ((raw >> 4'd4) != '0) begin
            return OP_NOOP;
        end else begin
            case (low)
                OP_REG_OP, OP_REG_IM, OP_BRA, OP_BRR, OP_BNE, OP_BNR,
                OP_LOD, OP_STR, OP_HLT: return low;
                default:                return OP_NOOP;
            endcase
        end
    endfunction

    // Opcode classification, branch condition and memory timeout detection.
    always_comb begin
        op_s        = decode_op(bus.opcode);
        cc_hit_s    = bus.stat & bus.mm;
        cond_s      = |cc_hit_s;
        is_branch_s = 1'b0;
        br_taken_s  = 1'b0;
        br_abs_s    = 1'b0;
        case (op_s)
            OP_BRA: begin is_branch_s = 1'b1; br_taken_s = cond_s;  br_abs_s = 1'b1; end
            OP_BRR: begin is_branch_s = 1'b1; br_taken_s = cond_s;  br_abs_s = 1'b0; end
            OP_BNE: begin is_branch_s = 1'b1; br_taken_s = !cond_s; br_abs_s = 1'b1; end
            OP_BNR: begin is_branch_s = 1'b1; br_taken_s = !cond_s; br_abs_s = 1'b0; end
            default: begin is_branch_s = 1'b0; br_taken_s = 1'b0; br_abs_s = 1'b0; end
        endcase
        is_mem_op_s = (op_s == OP_LOD) || (op_s == OP_STR);
        timeout_s   = TIMEOUT_EN && is_mem_op_s && !bus.mem_ack && (wait_cnt_r == LAST_WAIT);
    end

    // Next-state selection and control outputs decoded from state and opcode.
    always_comb begin
        state_nxt_s  = state_r;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.alu_op   = '0;
        bus.br_sel   = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_rst   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        case (state_r)
            ST_START: begin
                bus.pc_rst  = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
                state_nxt_s  = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_branch_s) begin
                    bus.pc_sel   = br_taken_s;
                    bus.pc_write = br_taken_s;
                    bus.br_sel   = br_taken_s && br_abs_s;
                    state_nxt_s  = ST_FETCH;
                end else if (op_s == OP_NOOP) begin
                    state_nxt_s = ST_FETCH;
                end else if (op_s == OP_HLT) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (op_s)
                    OP_REG_OP:                    bus.alu_op = ALU_W'(1);
                    OP_REG_IM, OP_LOD, OP_STR:    bus.alu_op = ALU_W'(3);
                    default:                      bus.alu_op = ALU_W'(0);
                endcase
                state_nxt_s = ST_MEM;
            end
            ST_MEM: begin
                if (is_mem_op_s) begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = (op_s == OP_STR);
                    bus.alu_op  = ALU_W'(2);
                    if (bus.mem_ack) begin
                        state_nxt_s = (op_s == OP_LOD) ? ST_WB : ST_FETCH;
                    end else if (timeout_s) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end else if (op_s == OP_REG_IM) begin
                    bus.alu_op  = ALU_W'(2);
                    state_nxt_s = ST_WB;
                end else begin
                    bus.alu_op  = ALU_W'(0);
                    state_nxt_s = ST_WB;
                end
            end
            ST_WB: begin
                bus.rf_we   = (op_s == OP_REG_OP) || (op_s == OP_REG_IM) || (op_s == OP_LOD);
                bus.wb_sel  = (op_s == OP_LOD);
                state_nxt_s = ST_FETCH;
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_START;
            end
        endcase
    end

    // State register; reset forces START at once, dropping mem_req with it.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r <= ST_START;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered status: halted tracks HALT, mem_err pulses on a timeout entry.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            halted_r  <= 1'b0;
            mem_err_r <= 1'b0;
        end else begin
            halted_r  <= (state_nxt_s == ST_HALT);
            mem_err_r <= (state_r == ST_MEM) && (state_nxt_s == ST_HALT);
        end
    end

    // MEM wait counter: counts un-acked MEM cycles, cleared on leaving MEM.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_MEM) && (state_nxt_s == ST_MEM)) begin
            if (wait_cnt_r != {CNT_W{1'b1}}) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= '0;
        end
    end

    assign bus.halted  = halted_r;
    assign bus.mem_err = mem_err_r;

`ifdef CTRL_MC_PERF_CNT_EN
    logic [31:0] retired_cnt_r;
    logic [31:0] stall_cnt_r;

    // Retirement and memory-stall counters, frozen while halted.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            retired_cnt_r <= 32'd0;
            stall_cnt_r   <= 32'd0;
        end else if (state_r != ST_HALT) begin
            if ((state_nxt_s == ST_FETCH) &&
                ((state_r == ST_DECODE) || (state_r == ST_MEM) || (state_r == ST_WB))) begin
                retired_cnt_r <= retired_cnt_r + 32'd1;
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
            if ((state_r == ST_MEM) && bus.mem_req && !bus.mem_ack) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            retired_cnt_r <= retired_cnt_r;
            stall_cnt_r   <= stall_cnt_r;
        end
    end

    assign retired_cnt = retired_cnt_r;
    assign stall_cnt   = stall_cnt_r;
`endif
endmodule
